// File: rtl/player_motion_pkg.sv
// Shared types and constants for the player motion block: FSM states,
// USB key codes and fixed-point width helpers.
package player_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } state_e;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_W = 8'h1A;

  localparam int DEF_POS_W  = 10;
  localparam int DEF_FRAC_W = 4;
  localparam int KEY_BYTES  = 4;

  // Unsigned position carries POS_W integer bits plus the fraction.
  function automatic int pos_bits(input int pos_w, input int frac_w);
    return pos_w + frac_w;
  endfunction

  // Velocity needs one extra bit for the sign.
  function automatic int vel_bits(input int pos_w, input int frac_w);
    return pos_w + frac_w + 1;
  endfunction

endpackage

// File: rtl/player_motion_key_decoder.sv
// Key decoder: matches the packed keycode bytes against A/D/W and keeps the
// jump key history so a jump only fires on a fresh press.
module key_decoder
  import player_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   step_i,
  input  logic [8*KEY_BYTES-1:0] keycode_i,
  output logic                   left_o,
  output logic                   right_o,
  output logic                   jump_o,
  output logic                   jump_rise_o
);

  logic [KEY_BYTES-1:0] is_a, is_d, is_w;
  logic                 jump_q;

  for (genvar b = 0; b < KEY_BYTES; b++) begin : g_byte
    assign is_a[b] = (keycode_i[8*b +: 8] == KEY_A);
    assign is_d[b] = (keycode_i[8*b +: 8] == KEY_D);
    assign is_w[b] = (keycode_i[8*b +: 8] == KEY_W);
  end

  assign left_o  = |is_a;
  assign right_o = |is_d;
  assign jump_o  = |is_w;

  // History is the W level seen at the previous step, not the previous clock.
  always_ff @(posedge clk_i) begin
    if (rst_i)       jump_q <= 1'b0;
    else if (step_i) jump_q <= jump_o;
  end

  assign jump_rise_o = jump_o & ~jump_q;

endmodule

// File: rtl/player_motion.sv
// Frame-stepped player physics: walk/jump decode, fixed-point integration
// with gravity, screen and ground clamping. Optional: PLAYER_VAR_JUMP_EN.
module player_motion
  import player_pkg::*;
#(
  parameter int POS_W     = DEF_POS_W,
  parameter int FRAC_W    = DEF_FRAC_W,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int Y_MIN     = 0,
  parameter int GROUND_Y  = 384,
  parameter int START_X   = 320,
  parameter int SIZE_X    = 8,
  parameter int SIZE_Y    = 16,
  parameter int WALK_V    = 32,
  parameter int JUMP_V    = 96,
  parameter int GRAVITY   = 4,
  parameter int VMAX_FALL = 128,
  parameter int JUMP_CUT  = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_clk,
  input  logic [31:0]      keycode,
  output logic [POS_W-1:0] PosX,
  output logic [POS_W-1:0] PosY,
  output logic [POS_W-1:0] SizeX,
  output logic [POS_W-1:0] SizeY,
  output logic             airborne,
  output logic             facing_left
);

  localparam int PW = pos_bits(POS_W, FRAC_W);
  localparam int VW = vel_bits(POS_W, FRAC_W);
  localparam int SW = VW + 1;

  typedef logic        [PW-1:0] pos_t;
  typedef logic signed [VW-1:0] vel_t;
  typedef logic signed [SW-1:0] sum_t;

  localparam sum_t X_LO   = sum_t'(X_MIN << FRAC_W);
  localparam sum_t X_HI   = sum_t'((X_MAX - SIZE_X) << FRAC_W);
  localparam sum_t Y_LO   = sum_t'(Y_MIN << FRAC_W);
  localparam sum_t Y_GND  = sum_t'(GROUND_Y << FRAC_W);
  localparam vel_t V_WALK = vel_t'(WALK_V);
  localparam vel_t V_JUMP = vel_t'(JUMP_V);
  localparam vel_t V_GRAV = vel_t'(GRAVITY);
  localparam vel_t V_MAX  = vel_t'(VMAX_FALL);
`ifdef PLAYER_VAR_JUMP_EN
  localparam vel_t V_CUT  = vel_t'(JUMP_CUT);
`endif

  logic   frame_q, step;
  logic   left, right, jump, jump_rise;
  state_e state_q, state_d;
  pos_t   x_q, x_d, y_q, y_d;
  vel_t   vy_q, vy_d, vx, vy_eff, vy_grav;
  sum_t   x_sum, y_sum;
  logic   face_q, face_d;

  assign step = frame_clk & ~frame_q;

  always_ff @(posedge Clk) begin
    if (Reset) frame_q <= 1'b0;
    else       frame_q <= frame_clk;
  end

  key_decoder u_keys (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .step_i      (step),
    .keycode_i   (keycode),
    .left_o      (left),
    .right_o     (right),
    .jump_o      (jump),
    .jump_rise_o (jump_rise)
  );

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Reset)     state_q <= GROUND;
    else if (step) state_q <= state_d;
  end

  // FSM next state plus vertical integrator
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vy_d    = vy_q;
    vy_eff  = vy_q;
`ifdef PLAYER_VAR_JUMP_EN
    if (state_q == RISE && !jump && vy_q < -V_CUT) vy_eff = -V_CUT;
`endif
    y_sum   = $signed({2'b00, y_q}) + sum_t'(vy_eff);
    vy_grav = vy_eff + V_GRAV;
    unique case (state_q)
      GROUND: begin
        vy_d = '0;
        if (jump_rise) begin
          vy_d    = -V_JUMP;
          state_d = RISE;
        end
      end
      RISE: begin
        if (y_sum < Y_LO) begin
          y_d     = pos_t'(Y_LO);
          vy_d    = '0;
          state_d = FALL;
        end else begin
          y_d  = pos_t'(y_sum);
          vy_d = vy_grav;
          if (!vy_grav[VW-1]) state_d = FALL;
        end
      end
      FALL: begin
        if (y_sum >= Y_GND) begin
          y_d     = pos_t'(Y_GND);
          vy_d    = '0;
          state_d = GROUND;
        end else begin
          y_d  = pos_t'(y_sum);
          vy_d = (vy_grav > V_MAX) ? V_MAX : vy_grav;
        end
      end
      default: begin
        state_d = GROUND;
        vy_d    = '0;
      end
    endcase
  end

  // Horizontal: clamp on the wide signed sum so walking left never wraps.
  always_comb begin
    vx     = '0;
    face_d = face_q;
    if (left && !right) vx = -V_WALK;
    if (right && !left) vx = V_WALK;
    if (left ^ right)   face_d = left;
    x_sum = $signed({2'b00, x_q}) + sum_t'(vx);
    if (x_sum < X_LO)      x_d = pos_t'(X_LO);
    else if (x_sum > X_HI) x_d = pos_t'(X_HI);
    else                   x_d = pos_t'(x_sum);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_q    <= pos_t'(START_X << FRAC_W);
      y_q    <= pos_t'(Y_GND);
      vy_q   <= '0;
      face_q <= 1'b0;
    end else if (step) begin
      x_q    <= x_d;
      y_q    <= y_d;
      vy_q   <= vy_d;
      face_q <= face_d;
    end
  end

  // FSM outputs
  always_comb begin
    airborne    = (state_q != GROUND);
    facing_left = face_q;
    PosX        = x_q[PW-1:FRAC_W];
    PosY        = y_q[PW-1:FRAC_W];
    SizeX       = POS_W'(SIZE_X);
    SizeY       = POS_W'(SIZE_Y);
  end

endmodule

// File: tb/tb_player_motion.sv
// Scoreboard bench for player_motion: expected snapshots are queued as each
// step is driven and popped once the registered outputs have updated.
module tb_player_motion;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [31:0] keycode = '0;
  logic [9:0]  PosX, PosY, SizeX, SizeY;
  logic        airborne, facing_left;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] K_NONE = 32'h0;
  localparam logic [31:0] K_A    = 32'h04;
  localparam logic [31:0] K_D    = 32'h07;
  localparam logic [31:0] K_D_HI = 32'h0007_0000;
  localparam logic [31:0] K_AD   = 32'h0704;
  localparam logic [31:0] K_W    = 32'h1A;
  localparam logic [31:0] K_WA   = 32'h041A;

  // Packed snapshot {PosX, PosY, airborne, facing_left}; mask marks checked bits.
  typedef struct {
    int         step;
    logic [21:0] val;
    logic [21:0] msk;
  } exp_t;

  exp_t sb[$];

  player_motion dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .keycode     (keycode),
    .PosX        (PosX),
    .PosY        (PosY),
    .SizeX       (SizeX),
    .SizeY       (SizeY),
    .airborne    (airborne),
    .facing_left (facing_left)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Negative field value means don't care.
  function automatic exp_t mk(input int s, input int x, input int y, input int air, input int face);
    exp_t e;
    e.step = s;
    e.val = '0;
    e.msk = '0;
    if (x >= 0)    begin e.val[21:12] = 10'(x);   e.msk[21:12] = '1; end
    if (y >= 0)    begin e.val[11:2]  = 10'(y);   e.msk[11:2]  = '1; end
    if (air >= 0)  begin e.val[1]     = 1'(air);  e.msk[1]     = 1'b1; end
    if (face >= 0) begin e.val[0]     = 1'(face); e.msk[0]     = 1'b1; end
    return e;
  endfunction

  function automatic logic [21:0] obs();
    return {PosX, PosY, airborne, facing_left};
  endfunction

  task automatic reset_dut();
    @(negedge Clk);
    Reset = 1'b1; frame_clk = 1'b0; keycode = K_NONE;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  // One frame strobe: high for one clock, then low long enough to re-arm.
  task automatic do_step(input logic [31:0] kc);
    @(negedge Clk);
    keycode = kc; frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    exp_t e;
    reset_dut();
    sb.push_back(mk(0, 320, 384, 0, 0));
    e = sb.pop_front();
    checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      errors++;
      $display("FAIL reset: got x=%0d y=%0d air=%0d face=%0d want %h/%h", PosX, PosY, airborne, facing_left, e.val, e.msk);
    end
    checks++;
    if (SizeX !== 10'd8 || SizeY !== 10'd16) begin
      errors++;
      $display("FAIL size: got %0dx%0d want 8x16", SizeX, SizeY);
    end
  endtask

  task automatic test_idle();
    exp_t e;
    reset_dut();
    for (int k = 1; k <= 5; k++) begin
      sb.push_back(mk(k, 320, 384, 0, 0));
      do_step(K_NONE);
      e = sb.pop_front();
      checks++;
      if ((obs() & e.msk) !== (e.val & e.msk)) begin
        errors++;
        $display("FAIL idle step %0d: got x=%0d y=%0d air=%0d want %h/%h", e.step, PosX, PosY, airborne, e.val, e.msk);
      end
    end
  endtask

  task automatic test_walk();
    exp_t e;
    logic [31:0] kc;
    reset_dut();
    for (int k = 1; k <= 13; k++) begin
      kc = (k <= 5) ? K_D : (k <= 10) ? K_D_HI : K_AD;
      sb.push_back(mk(k, (k <= 10) ? 320 + 2*k : 340, 384, 0, 0));
      do_step(kc);
      e = sb.pop_front();
      checks++;
      if ((obs() & e.msk) !== (e.val & e.msk)) begin
        errors++;
        $display("FAIL walk step %0d: got x=%0d y=%0d face=%0d want %h/%h", e.step, PosX, PosY, facing_left, e.val, e.msk);
      end
    end
  endtask

  // A long high level on frame_clk must count as a single step.
  task automatic test_held_frame();
    exp_t e;
    reset_dut();
    sb.push_back(mk(1, 322, 384, 0, 0));
    @(negedge Clk);
    keycode = K_D; frame_clk = 1'b1;
    repeat (20) @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
    e = sb.pop_front();
    checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      errors++;
      $display("FAIL held_frame: got x=%0d want %h/%h", PosX, e.val, e.msk);
    end
  endtask

  task automatic test_walls();
    exp_t e;
    reset_dut();
    for (int k = 1; k <= 165; k++) begin
      sb.push_back(mk(k, (320 - 2*k < 0) ? 0 : 320 - 2*k, 384, 0, 1));
      do_step(K_A);
      e = sb.pop_front();
      checks++;
      if ((obs() & e.msk) !== (e.val & e.msk)) begin
        errors++;
        $display("FAIL left_wall step %0d: got x=%0d face=%0d want %h/%h", e.step, PosX, facing_left, e.val, e.msk);
      end
    end
    reset_dut();
    for (int k = 1; k <= 160; k++) begin
      sb.push_back(mk(k, (320 + 2*k > 631) ? 631 : 320 + 2*k, 384, 0, 0));
      do_step(K_D);
      e = sb.pop_front();
      checks++;
      if ((obs() & e.msk) !== (e.val & e.msk)) begin
        errors++;
        $display("FAIL right_wall step %0d: got x=%0d want %h/%h", e.step, PosX, e.val, e.msk);
      end
    end
  endtask

`ifndef PLAYER_VAR_JUMP_EN
  task automatic test_jump();
    exp_t e;
    int y;
    reset_dut();
    for (int k = 0; k <= 52; k++) begin
      y = (k == 0) ? 384 : (k == 1) ? 378 : (k == 24 || k == 25) ? 309 : (k >= 49) ? 384 : -1;
      sb.push_back(mk(k, 320, y, (k >= 49) ? 0 : 1, 0));
      do_step((k == 0) ? K_W : K_NONE);
      e = sb.pop_front();
      checks++;
      if ((obs() & e.msk) !== (e.val & e.msk)) begin
        errors++;
        $display("FAIL jump step %0d: got y=%0d air=%0d want %h/%h", e.step, PosY, airborne, e.val, e.msk);
      end
    end
  endtask
`else
  task automatic test_var_jump();
    exp_t e;
    int y;
    reset_dut();
    for (int k = 0; k <= 12; k++) begin
      y = (k == 1) ? 378 : (k == 4) ? 364 : (k == 11) ? 357 : -1;
      sb.push_back(mk(k, 320, y, 1, 0));
      do_step((k <= 3) ? K_W : K_NONE);
      e = sb.pop_front();
      checks++;
      if ((obs() & e.msk) !== (e.val & e.msk)) begin
        errors++;
        $display("FAIL var_jump step %0d: got y=%0d air=%0d want %h/%h", e.step, PosY, airborne, e.val, e.msk);
      end
    end
  endtask
`endif

  // W held through the landing must not re-launch until released and re-pressed.
  task automatic test_hold_w();
    exp_t e;
    logic [31:0] kc;
    int y;
    reset_dut();
    for (int k = 0; k <= 62; k++) begin
      kc = (k <= 59 || k >= 61) ? K_W : K_NONE;
      y  = (k >= 49 && k <= 61) ? 384 : (k == 62) ? 378 : -1;
      sb.push_back(mk(k, 320, y, (k >= 49 && k <= 60) ? 0 : 1, 0));
      do_step(kc);
      e = sb.pop_front();
      checks++;
      if ((obs() & e.msk) !== (e.val & e.msk)) begin
        errors++;
        $display("FAIL hold_w step %0d: got y=%0d air=%0d want %h/%h", e.step, PosY, airborne, e.val, e.msk);
      end
    end
  endtask

  task automatic test_reset_mid_jump();
    exp_t e;
    reset_dut();
    for (int k = 0; k <= 9; k++) begin
      sb.push_back(mk(k, 320 - 2*(k + 1), -1, 1, 1));
      do_step((k == 0) ? K_WA : K_A);
      e = sb.pop_front();
      checks++;
      if ((obs() & e.msk) !== (e.val & e.msk)) begin
        errors++;
        $display("FAIL pre_reset step %0d: got x=%0d air=%0d want %h/%h", e.step, PosX, airborne, e.val, e.msk);
      end
    end
    // Reset lands on the same cycle as a frame step; reset must win.
    sb.push_back(mk(10, 320, 384, 0, 0));
    @(negedge Clk);
    Reset = 1'b1; frame_clk = 1'b1; keycode = K_A;
    @(negedge Clk);
    Reset = 1'b0; frame_clk = 1'b0; keycode = K_NONE;
    e = sb.pop_front();
    checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      errors++;
      $display("FAIL reset_mid_jump: got x=%0d y=%0d air=%0d face=%0d want %h/%h", PosX, PosY, airborne, facing_left, e.val, e.msk);
    end
    sb.push_back(mk(11, 320, 384, 0, 0));
    do_step(K_NONE);
    e = sb.pop_front();
    checks++;
    if ((obs() & e.msk) !== (e.val & e.msk)) begin
      errors++;
      $display("FAIL post_reset_ground: got y=%0d air=%0d want %h/%h", PosY, airborne, e.val, e.msk);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_walk();
    test_held_frame();
    test_walls();
`ifndef PLAYER_VAR_JUMP_EN
    test_jump();
`else
    test_var_jump();
`endif
    test_hold_w();
    test_reset_mid_jump();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
